uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter handing one requester at a time
// to a shared UART transmitter and reporting a done/err pulse per transfer.
module uart_tx_scheduler #(
    parameter int          NUM_REQ = 4,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [16:0]                cfg_baud,
    input  logic [3:0]                 cfg_length,
    input  logic                       cfg_parity_type,
    input  logic                       cfg_parity_en,
    input  logic                       cfg_stop2,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [16:0]                baud,
    output logic [3:0]                 length,
    output logic                       parity_type,
    output logic                       parity_en,
    output logic                       stop2,
    input  logic                       tx_done,
    input  logic                       tx_err
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_idx;
    logic [7:0]    r_data;
    logic [7:0]    w_byte;
    logic [16:0]   r_baud;
    logic [3:0]    r_len;
    logic          r_ptype;
    logic          r_pen;
    logic          r_stop2;
    logic [19:0]   r_timer;
    logic [19:0]   w_tmr_nxt;
    logic          r_fail;
    logic          w_found;
    logic          w_tmo;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        w_byte  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IW'((int'(r_last) + 1 + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == w_pick) begin
                w_byte = req_data[8*k +: 8];
            end
        end
    end

    // Abandon on the edge where the timer would step onto TIMEOUT-1.
    assign w_tmr_nxt = r_timer + 20'd1;
    assign w_tmo     = (w_tmr_nxt == TIMEOUT - 20'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_start = 1'b0;
        gnt      = '0;
        done     = '0;
        err      = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next = START;
                end
            end
            START: begin
                tx_start     = 1'b1;
                gnt[r_owner] = 1'b1;
                w_next       = WAIT;
            end
            WAIT: begin
                if (tx_done || w_tmo) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (r_fail) begin
                    err[r_owner] = 1'b1;
                end else begin
                    done[r_owner] = 1'b1;
                end
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_data  <= '0;
            r_baud  <= '0;
            r_len   <= '0;
            r_ptype <= 1'b0;
            r_pen   <= 1'b0;
            r_stop2 <= 1'b0;
            r_timer <= '0;
            r_fail  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_owner <= w_pick;
                r_data  <= w_byte;
                r_baud  <= cfg_baud;
                r_len   <= cfg_length;
                r_ptype <= cfg_parity_type;
                r_pen   <= cfg_parity_en;
                r_stop2 <= cfg_stop2;
            end
            if (r_state == START) begin
                r_timer <= '0;
                r_fail  <= 1'b0;
            end else if (r_state == WAIT) begin
                r_timer <= w_tmr_nxt;
                if (tx_err || (w_tmo && !tx_done)) begin
                    r_fail <= 1'b1;
                end
            end
            if (r_state == DONE) begin
                r_last <= r_owner;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign owner       = r_owner;
    assign tx_data     = r_data;
    assign baud        = r_baud;
    assign length      = r_len;
    assign parity_type = r_ptype;
    assign parity_en   = r_pen;
    assign stop2       = r_stop2;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single, contention, error,
// timeout, done/timeout tie and mid-transfer reset scenarios.
module tb_uart_tx_scheduler;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [16:0] cfg_baud;
    logic [3:0]  cfg_length;
    logic        cfg_parity_type;
    logic        cfg_parity_en;
    logic        cfg_stop2;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic [1:0]  owner;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [16:0] baud;
    logic [3:0]  length;
    logic        parity_type;
    logic        parity_en;
    logic        stop2;
    logic        tx_done;
    logic        tx_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_start;
    int t0;
    bit seen;

    uart_tx_scheduler #(
        .NUM_REQ(4),
        .TIMEOUT(20'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .cfg_baud(cfg_baud),
        .cfg_length(cfg_length),
        .cfg_parity_type(cfg_parity_type),
        .cfg_parity_en(cfg_parity_en),
        .cfg_stop2(cfg_stop2),
        .gnt(gnt),
        .done(done),
        .err(err),
        .busy(busy),
        .owner(owner),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .baud(baud),
        .length(length),
        .parity_type(parity_type),
        .parity_en(parity_en),
        .stop2(stop2),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_baud"}, 32'(baud), 32'd0);
        chk({tag, "_cfg"}, 32'({length, parity_type, parity_en, stop2}), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        tx_done = 1'b0;
        tx_err = 1'b0;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        cfg_baud = 17'd0;
        cfg_length = 4'd0;
        cfg_parity_type = 1'b0;
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b0;

        step();
        step();
        chk_cleared("rst");
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // single request from requester 2
        cfg_baud = 17'd868;
        cfg_length = 4'd8;
        cfg_parity_type = 1'b1;
        cfg_parity_en = 1'b1;
        cfg_stop2 = 1'b1;
        req = 4'b0100;
        step();
        chk("s_gnt", 32'(gnt), 32'h4);
        chk("s_start", 32'(tx_start), 32'd1);
        chk("s_busy", 32'(busy), 32'd1);
        chk("s_owner", 32'(owner), 32'd2);
        chk("s_data", 32'(tx_data), 32'hA5);
        chk("s_baud", 32'(baud), 32'd868);
        chk("s_cfg", 32'({length, parity_type, parity_en, stop2}), 32'h47);
        cfg_baud = 17'd5;
        cfg_length = 4'd7;
        req_data[23:16] = 8'h3C;
        step();
        chk("s_gnt_pulse", 32'(gnt), 32'd0);
        chk("s_start_pulse", 32'(tx_start), 32'd0);
        chk("s_baud_hold", 32'(baud), 32'd868);
        chk("s_data_hold", 32'(tx_data), 32'hA5);
        repeat (9) step();
        chk("s_wait_busy", 32'(busy), 32'd1);
        chk("s_wait_done", 32'(done), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        req = '0;
        chk("s_done", 32'(done), 32'h4);
        chk("s_err", 32'(err), 32'd0);
        step();
        chk("s_idle_busy", 32'(busy), 32'd0);
        chk("s_idle_done", 32'(done), 32'd0);
        chk("s_idle_data", 32'(tx_data), 32'hA5);
        chk("s_idle_len", 32'(length), 32'd8);
        req_data[23:16] = 8'hA5;

        // stray tx_done/tx_err while idle
        tx_done = 1'b1;
        tx_err = 1'b1;
        step();
        step();
        chk("ig_busy", 32'(busy), 32'd0);
        chk("ig_done", 32'(done), 32'd0);
        chk("ig_err", 32'(err), 32'd0);
        tx_done = 1'b0;
        tx_err = 1'b0;

        // contention with all four requesting
        do_reset();
        req = 4'b1111;
        last_start = -100;
        for (int g = 0; g < 5; g++) begin
            wait_start(10, seen);
            chk("c_seen", 32'(seen), 32'd1);
            chk("c_gnt", 32'(gnt), 32'(1 << (g % 4)));
            chk("c_space", 32'(cyc - last_start >= 4), 32'd1);
            last_start = cyc;
            tx_done = 1'b1;
            step();
            chk("c_start_pulse", 32'(tx_start), 32'd0);
            step();
            chk("c_done", 32'(done), 32'(1 << (g % 4)));
            tx_done = 1'b0;
            if (g == 4) req = '0;
        end
        step();
        chk("c_idle", 32'(busy), 32'd0);

        // error together with done, requester 1
        req = 4'b0010;
        wait_start(10, seen);
        chk("e_seen", 32'(seen), 32'd1);
        chk("e_gnt", 32'(gnt), 32'h2);
        step();
        tx_done = 1'b1;
        tx_err = 1'b1;
        step();
        tx_done = 1'b0;
        tx_err = 1'b0;
        chk("e_err", 32'(err), 32'h2);
        chk("e_done", 32'(done), 32'd0);

        // error ahead of done is remembered
        wait_start(10, seen);
        chk("e2_gnt", 32'(gnt), 32'h2);
        step();
        tx_err = 1'b1;
        step();
        tx_err = 1'b0;
        chk("e2_wait", 32'(busy), 32'd1);
        chk("e2_noerr", 32'(err), 32'd0);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        req = '0;
        chk("e2_err", 32'(err), 32'h2);
        chk("e2_done", 32'(done), 32'd0);
        step();

        // timeout, tx_done never returned
        req = 4'b0001;
        wait_start(10, seen);
        chk("t_gnt", 32'(gnt), 32'h1);
        t0 = cyc;
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if ((err | done) !== 4'd0) seen = 1'b1;
        end
        chk("t_seen", 32'(seen), 32'd1);
        chk("t_lat", 32'(cyc - t0), 32'd16);
        chk("t_err", 32'(err), 32'h1);
        chk("t_done", 32'(done), 32'd0);
        step();
        chk("t_idle", 32'(busy), 32'd0);

        // tx_done on the timeout edge wins
        req = 4'b0100;
        wait_start(10, seen);
        chk("tie_gnt", 32'(gnt), 32'h4);
        req = '0;
        repeat (15) step();
        chk("tie_busy", 32'(busy), 32'd1);
        chk("tie_early", 32'(err | done), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("tie_done", 32'(done), 32'h4);
        chk("tie_err", 32'(err), 32'd0);
        step();

        // reset in the middle of WAIT
        req = 4'b0100;
        wait_start(10, seen);
        chk("r_gnt", 32'(gnt), 32'h4);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_cleared("r_async");
        req = 4'b1001;
        tx_done = 1'b1;
        step();
        chk("r_h1", 32'({busy, done, err}), 32'd0);
        step();
        chk("r_h2", 32'({busy, done, err}), 32'd0);
        tx_done = 1'b0;
        rst = 1'b1;
        chk("r_nogrant", 32'(gnt), 32'd0);
        wait_start(10, seen);
        chk("r_seen", 32'(seen), 32'd1);
        chk("r_gnt0", 32'(gnt), 32'h1);
        chk("r_owner0", 32'(owner), 32'd0);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("r_done0", 32'(done), 32'h1);
        wait_start(10, seen);
        chk("r_gnt3", 32'(gnt), 32'h8);
        req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
